// File: rtl/clock_set_ctrl_pkg.sv
// rtl/clock_set_ctrl_pkg.sv - shared state encodings, button indices and field limits for clock_set_ctrl
package clock_set_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN          = 3'd0,
        SET_HOUR     = 3'd1,
        SET_MIN      = 3'd2,
        SET_ALM_HOUR = 3'd3,
        SET_ALM_MIN  = 3'd4
    } state_t;

    localparam int BTN_MODE = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;

    // Step one unit up or down, wrapping within 0..max.
    function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max, input logic up);
        logic [5:0] res;
        res = val;
        if (up) begin
            res = (val >= max) ? 6'd0 : val + 6'd1;
        end else begin
            res = (val == 6'd0) ? max : val - 6'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_repeat.sv
// rtl/clock_set_ctrl_repeat.sv - pb_repeat_gen: press step plus hold-to-repeat step pulses
module pb_repeat_gen #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    input  logic i_pulse,
    input  logic i_clear,
    output logic o_step
);

    localparam int MAXP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(MAXP) + 1;
    localparam logic [CW-1:0] L_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] L_PERIOD = CW'(REPEAT_PERIOD);

    logic [CW-1:0] r_cnt;
    logic          r_rep;
    logic [CW-1:0] w_cnt_inc;
    logic          w_hit;

    // r_rep selects between the initial delay and the repeat period.
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_hit     = i_level && !i_pulse && !i_clear && (w_cnt_inc == (r_rep ? L_PERIOD : L_DELAY));
    assign o_step    = !i_clear && (i_pulse || w_hit);

    always_ff @(posedge clk) begin
        if (rst || i_clear || i_pulse || !i_level) begin
            r_cnt <= '0;
            r_rep <= 1'b0;
        end else if (w_hit) begin
            r_cnt <= '0;
            r_rep <= 1'b1;
        end else begin
            r_cnt <= w_cnt_inc;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time/alarm setting sequencer driven by MODE/UP/DOWN debounced buttons
import clock_set_ctrl_pkg::*;

module clock_set_ctrl #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int BLINK_HALF    = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pb_pressed_pulse,
    input  logic [2:0] pb_pressed_status,
    input  logic [2:0] pb_released_pulse,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [4:0] alm_hour,
    input  logic [5:0] alm_min,
    output logic [4:0] edit_hour,
    output logic [5:0] edit_min,
    output logic       time_load,
    output logic       alarm_load,
    output logic [2:0] state_o,
    output logic       blink
);

    localparam int MW = $clog2(LONG_CYCLES) + 1;
    localparam int BW = $clog2(BLINK_HALF) + 1;
    localparam logic [MW-1:0] L_LONG  = MW'(LONG_CYCLES);
    localparam logic [BW-1:0] L_BLINK = BW'(BLINK_HALF);

    state_t        r_state, w_state_nxt;
    logic [MW-1:0] r_mode_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic [4:0]    r_edit_hour;
    logic [5:0]    r_edit_min;
    logic          r_time_load, r_alarm_load, r_blink;

    logic w_mode_long, w_mode_short, w_conflict, w_state_chg, w_clear_base;
    logic w_up_step, w_dn_step, w_step, w_is_hour;
    logic w_ld_cur, w_time_ld, w_alm_ld;

    assign w_mode_long  = pb_pressed_status[BTN_MODE] && !pb_pressed_pulse[BTN_MODE] && (r_mode_cnt == L_LONG - MW'(1));
    assign w_mode_short = pb_released_pulse[BTN_MODE] && (r_mode_cnt < L_LONG);
    assign w_conflict   = (pb_pressed_status[BTN_UP] && pb_pressed_status[BTN_DOWN]) ||
                          (pb_pressed_pulse[BTN_UP] && pb_pressed_pulse[BTN_DOWN]);
    assign w_state_chg  = (w_state_nxt != r_state);
    assign w_clear_base = w_conflict || w_state_chg || (r_state == RUN);
    assign w_is_hour    = (r_state == SET_HOUR) || (r_state == SET_ALM_HOUR);
    assign w_step       = (w_up_step ^ w_dn_step) && (r_state != RUN) && !w_state_chg;

    pb_repeat_gen #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_up (
        .clk(clk), .rst(rst),
        .i_level(pb_pressed_status[BTN_UP]), .i_pulse(pb_pressed_pulse[BTN_UP]),
        .i_clear(w_clear_base || pb_released_pulse[BTN_UP]), .o_step(w_up_step)
    );

    pb_repeat_gen #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_dn (
        .clk(clk), .rst(rst),
        .i_level(pb_pressed_status[BTN_DOWN]), .i_pulse(pb_pressed_pulse[BTN_DOWN]),
        .i_clear(w_clear_base || pb_released_pulse[BTN_DOWN]), .o_step(w_dn_step)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // A long hold aborts any edit; otherwise a short release advances the walk.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_cur    = 1'b0;
        w_time_ld   = 1'b0;
        w_alm_ld    = 1'b0;
        if (r_state != RUN && w_mode_long) begin
            w_state_nxt = RUN;
        end else if (w_mode_short) begin
            case (r_state)
                RUN:          begin w_state_nxt = SET_HOUR; w_ld_cur = 1'b1; end
                SET_HOUR:     w_state_nxt = SET_MIN;
                SET_MIN:      begin w_state_nxt = SET_ALM_HOUR; w_time_ld = 1'b1; end
                SET_ALM_HOUR: w_state_nxt = SET_ALM_MIN;
                SET_ALM_MIN:  begin w_state_nxt = RUN; w_alm_ld = 1'b1; end
                default:      w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_cnt   <= '0;
            r_blink_cnt  <= '0;
            r_edit_hour  <= '0;
            r_edit_min   <= '0;
            r_time_load  <= 1'b0;
            r_alarm_load <= 1'b0;
            r_blink      <= 1'b0;
        end else begin
            if (pb_pressed_pulse[BTN_MODE])
                r_mode_cnt <= '0;
            else if (pb_pressed_status[BTN_MODE] && r_mode_cnt != L_LONG)
                r_mode_cnt <= r_mode_cnt + MW'(1);

            r_time_load  <= w_time_ld;
            r_alarm_load <= w_alm_ld;

            // Alarm values replace the edit regs only after the time commit strobe.
            if (w_ld_cur) begin
                r_edit_hour <= cur_hour;
                r_edit_min  <= cur_min;
            end else if (r_time_load) begin
                r_edit_hour <= alm_hour;
                r_edit_min  <= alm_min;
            end else if (w_step) begin
                if (w_is_hour) r_edit_hour <= 5'(wrap_step({1'b0, r_edit_hour}, HOUR_MAX, w_up_step));
                else           r_edit_min  <= wrap_step(r_edit_min, MIN_MAX, w_up_step);
            end

            if (w_state_nxt == RUN) begin
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end else if (w_state_chg || w_step) begin
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == L_BLINK - BW'(1)) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign edit_hour  = r_edit_hour;
    assign edit_min   = r_edit_min;
    assign time_load  = r_time_load;
    assign alarm_load = r_alarm_load;
    assign state_o    = r_state;
    assign blink      = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - table-driven and sequence checks for clock_set_ctrl
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] pp, ps, pr;
    logic [4:0] ch, ah;
    logic [5:0] cm, am;
    logic [4:0] edit_hour;
    logic [5:0] edit_min;
    logic       time_load, alarm_load, blink;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] M = 3'b001;
    localparam logic [2:0] U = 3'b010;
    localparam logic [2:0] D = 3'b100;
    localparam logic [2:0] Z = 3'b000;

    typedef struct {
        logic [2:0] pp, ps, pr;
        int         ch, cm;
        int         st, eh, em, tl, al, bl;
    } vec_t;

    vec_t tbl[$];

    clock_set_ctrl #(.LONG_CYCLES(8), .REPEAT_DELAY(6), .REPEAT_PERIOD(3), .BLINK_HALF(4)) dut (
        .clk(clk), .rst(rst),
        .pb_pressed_pulse(pp), .pb_pressed_status(ps), .pb_released_pulse(pr),
        .cur_hour(ch), .cur_min(cm), .alm_hour(ah), .alm_min(am),
        .edit_hour(edit_hour), .edit_min(edit_min),
        .time_load(time_load), .alarm_load(alarm_load),
        .state_o(state_o), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] a_pp, input logic [2:0] a_ps, input logic [2:0] a_pr,
                       input int a_ch, input int a_cm, input int a_st, input int a_eh, input int a_em,
                       input int a_tl, input int a_al, input int a_bl);
        vec_t v;
        v.pp = a_pp; v.ps = a_ps; v.pr = a_pr; v.ch = a_ch; v.cm = a_cm;
        v.st = a_st; v.eh = a_eh; v.em = a_em; v.tl = a_tl; v.al = a_al; v.bl = a_bl;
        tbl.push_back(v);
    endtask

    task automatic short_mode();
        pp = M; ps = M; cyc(); pp = Z;
        ps = Z; pr = M; cyc(); pr = Z;
    endtask

    task automatic chk_strobes(input string nm, input int tl, input int al);
        chk({nm, " time_load"}, int'(time_load), tl);
        chk({nm, " alarm_load"}, int'(alarm_load), al);
    endtask

    initial begin
        int exp_min;
        int last_tr;
        int n_tr;
        logic prev_bl;

        rst = 1'b1; pp = Z; ps = Z; pr = Z;
        ch = 5'd12; cm = 6'd34; ah = 5'd6; am = 6'd30;
        cyc(); cyc();
        chk("reset state", int'(state_o), 0);
        chk("reset hour", int'(edit_hour), 0);
        chk("reset min", int'(edit_min), 0);
        chk("reset blink", int'(blink), 0);
        chk_strobes("reset", 0, 0);
        rst = 1'b0;

        // Full short-MODE walk with commit strobes, then wrap-around steps.
        add(M, M, Z, 12, 34, 0,  0, 0,  0, 0, 0);
        add(Z, Z, M, 12, 34, 1, 12, 34, 0, 0, 1);
        add(M, M, Z, 12, 34, 1, 12, 34, 0, 0, 1);
        add(Z, Z, M, 12, 34, 2, 12, 34, 0, 0, 1);
        add(M, M, Z, 12, 34, 2, 12, 34, 0, 0, 1);
        add(Z, Z, M, 12, 34, 3, 12, 34, 1, 0, 1);
        add(Z, Z, Z, 12, 34, 3,  6, 30, 0, 0, 1);
        add(M, M, Z, 12, 34, 3,  6, 30, 0, 0, 1);
        add(Z, Z, M, 12, 34, 4,  6, 30, 0, 0, 1);
        add(M, M, Z, 12, 34, 4,  6, 30, 0, 0, 1);
        add(Z, Z, M, 12, 34, 0,  6, 30, 0, 1, 0);
        add(Z, Z, Z, 12, 34, 0,  6, 30, 0, 0, 0);
        add(M, M, Z, 23, 59, 0,  6, 30, 0, 0, 0);
        add(Z, Z, M, 23, 59, 1, 23, 59, 0, 0, 1);
        add(U, U, Z, 23, 59, 1,  0, 59, 0, 0, 1);
        add(Z, Z, U, 23, 59, 1,  0, 59, 0, 0, 1);
        add(D, D, Z, 23, 59, 1, 23, 59, 0, 0, 1);
        add(Z, Z, D, 23, 59, 1, 23, 59, 0, 0, 1);
        add(M, M, Z, 23, 59, 1, 23, 59, 0, 0, 1);
        add(Z, Z, M, 23, 59, 2, 23, 59, 0, 0, 1);
        add(U, U, Z, 23, 59, 2, 23,  0, 0, 0, 1);
        add(Z, Z, U, 23, 59, 2, 23,  0, 0, 0, 1);
        add(D, D, Z, 23, 59, 2, 23, 59, 0, 0, 1);
        add(Z, Z, D, 23, 59, 2, 23, 59, 0, 0, 1);

        foreach (tbl[i]) begin
            pp = tbl[i].pp; ps = tbl[i].ps; pr = tbl[i].pr;
            ch = 5'(tbl[i].ch); cm = 6'(tbl[i].cm);
            cyc();
            pp = Z; pr = Z;
            chk($sformatf("row%0d state", i), int'(state_o), tbl[i].st);
            chk($sformatf("row%0d hour", i), int'(edit_hour), tbl[i].eh);
            chk($sformatf("row%0d min", i), int'(edit_min), tbl[i].em);
            chk_strobes($sformatf("row%0d", i), tbl[i].tl, tbl[i].al);
            chk($sformatf("row%0d blink", i), int'(blink), tbl[i].bl);
        end

        // Long MODE hold in SET_MIN aborts on hold count 8 with no commit.
        pp = M; ps = M; cyc(); pp = Z;
        chk("long t0 state", int'(state_o), 2);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk($sformatf("long t%0d state", i), int'(state_o), (i >= 8) ? 0 : 2);
            chk_strobes($sformatf("long t%0d", i), 0, 0);
        end
        ps = Z; pr = M; cyc(); pr = Z;
        chk("long release state", int'(state_o), 0);
        chk_strobes("long release", 0, 0);
        cyc();
        chk("long after state", int'(state_o), 0);
        chk_strobes("long after", 0, 0);

        // Auto-repeat: UP held from edit_min=10 in SET_MIN.
        ch = 5'd12; cm = 6'd10;
        short_mode();
        short_mode();
        chk("rep entry state", int'(state_o), 2);
        chk("rep entry min", int'(edit_min), 10);
        exp_min = 10;
        for (int t = 0; t <= 15; t++) begin
            pp = (t == 0) ? U : Z;
            ps = U;
            cyc();
            pp = Z;
            if (t == 0 || (t >= 6 && (t - 6) % 3 == 0)) exp_min++;
            chk($sformatf("rep t%0d min", t), int'(edit_min), exp_min);
        end
        ps = Z; pr = U; cyc(); pr = Z;
        chk("rep final min", int'(edit_min), 15);

        // Conflict: both pulsed then both held -> no step, blink free-runs with period 4.
        pp = U | D; ps = U | D;
        last_tr = -1; n_tr = 0; prev_bl = blink;
        for (int t = 0; t <= 10; t++) begin
            cyc();
            pp = Z;
            chk($sformatf("conflict t%0d min", t), int'(edit_min), 15);
            if (blink != prev_bl) begin
                if (last_tr >= 0) chk($sformatf("conflict blink gap t%0d", t), t - last_tr, 4);
                last_tr = t;
                n_tr++;
            end
            prev_bl = blink;
        end
        chk("conflict blink toggles", (n_tr >= 2) ? 1 : 0, 1);
        ps = Z; pr = U | D; cyc(); pr = Z;
        chk("conflict release min", int'(edit_min), 15);

        // Commit the time, then reset while in SET_ALM_HOUR.
        short_mode();
        chk("alm entry state", int'(state_o), 3);
        chk("alm entry hour", int'(edit_hour), 12);
        chk("alm entry min", int'(edit_min), 15);
        chk_strobes("alm entry", 1, 0);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midrst state", int'(state_o), 0);
        chk("midrst hour", int'(edit_hour), 0);
        chk("midrst min", int'(edit_min), 0);
        chk("midrst blink", int'(blink), 0);
        chk_strobes("midrst", 0, 0);
        cyc();
        chk("postrst state", int'(state_o), 0);
        chk_strobes("postrst", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
